// File: rtl/i_serdes_align_pkg.sv
// ---------------------------------------------------------------------------
// i_serdes_align_pkg
// Shared types and constants for the I_SERDES bring-up / word-alignment
// controller: the controller state encoding, counter widths and small
// state-classification helpers used by the top-level FSM.
// ---------------------------------------------------------------------------
package i_serdes_align_pkg;

    localparam int SLIP_CNT_W  = 4;
    localparam int MATCH_CNT_W = 8;
    localparam int CYC_CNT_W   = 8;
    localparam int MAX_WIDTH   = 10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_CHECK     = 3'd3,
        ST_SLIP      = 3'd4,
        ST_SETTLE    = 3'd5,
        ST_LOCKED    = 3'd6,
        ST_ERROR     = 3'd7
    } align_state_e;

    // States that fall back to WAIT_LOCK when the synchronized lock drops.
    // ERROR is deliberately excluded: it is only left by dropping START.
    function automatic logic lock_watched(input align_state_e s);
        case (s)
            ST_RELEASE, ST_CHECK, ST_SLIP, ST_SETTLE, ST_LOCKED: lock_watched = 1'b1;
            default:                                             lock_watched = 1'b0;
        endcase
    endfunction

    // States in which the deserializer is out of reset and enabled.
    function automatic logic serdes_enabled(input align_state_e s);
        case (s)
            ST_CHECK, ST_SLIP, ST_SETTLE, ST_LOCKED, ST_ERROR: serdes_enabled = 1'b1;
            default:                                          serdes_enabled = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/i_serdes_align_ctrl_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level (PLL lock).
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, output resets to 0
//   d     - asynchronous input level
//   q     - synchronized level, two clk edges behind d
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_d;
    logic meta_q;
    logic sync_d;
    logic sync_q;

    // Next values of the two synchronizer stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/i_serdes_align_ctrl.sv
// ---------------------------------------------------------------------------
// i_serdes_align_ctrl
// Bring-up and word-alignment controller for one I_SERDES receive channel.
// Waits for PLL lock, holds the deserializer in reset for RX_RST_CYCLES,
// then compares deserialized words with TRAIN_PATTERN and pulses BITSLIP_ADJ
// until MATCH_COUNT consecutive valid matches are seen (ALIGNED) or the slip
// budget MAX_SLIPS is used up (ALIGN_ERROR, sticky until START drops).
// Ports:
//   CLK_IN            - fabric clock (I_SERDES CLK_OUT domain)
//   RST               - asynchronous active-low reset
//   START             - level enable; low returns the controller to IDLE
//   PLL_LOCK          - asynchronous PLL lock, synchronized internally
//   SERDES_Q          - deserialized word
//   SERDES_DATA_VALID - word qualifier
//   RX_RST            - deserializer reset, active-low
//   EN                - deserializer enable
//   BITSLIP_ADJ       - single-cycle bitslip request
//   ALIGNED           - channel aligned
//   ALIGN_ERROR       - slip budget exhausted
//   SLIP_COUNT        - bitslips issued since the last WAIT_LOCK entry
// All outputs are registered.
// ---------------------------------------------------------------------------
module i_serdes_align_ctrl
    import i_serdes_align_pkg::*;
#(
    parameter int                   WIDTH         = 4,
    parameter logic [MAX_WIDTH-1:0] TRAIN_PATTERN = 10'h00A,
    parameter int                   MATCH_COUNT   = 16,
    parameter int                   SLIP_WAIT     = 4,
    parameter int                   MAX_SLIPS     = 10,
    parameter int                   RX_RST_CYCLES = 8
) (
    input  logic                  CLK_IN,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  PLL_LOCK,
    input  logic [WIDTH-1:0]      SERDES_Q,
    input  logic                  SERDES_DATA_VALID,
    output logic                  RX_RST,
    output logic                  EN,
    output logic                  BITSLIP_ADJ,
    output logic                  ALIGNED,
    output logic                  ALIGN_ERROR,
    output logic [SLIP_CNT_W-1:0] SLIP_COUNT
);

    localparam logic [WIDTH-1:0]       PATTERN_C      = TRAIN_PATTERN[WIDTH-1:0];
    localparam logic [CYC_CNT_W-1:0]   RX_RST_LOAD_C  = CYC_CNT_W'(RX_RST_CYCLES);
    localparam logic [CYC_CNT_W-1:0]   SETTLE_LOAD_C  = CYC_CNT_W'(SLIP_WAIT);
    localparam logic [MATCH_CNT_W-1:0] MATCH_TARGET_C = MATCH_CNT_W'(MATCH_COUNT);
    localparam logic [SLIP_CNT_W-1:0]  MAX_SLIPS_C    = SLIP_CNT_W'(MAX_SLIPS);
    localparam logic [CYC_CNT_W-1:0]   CYC_ONE_C      = CYC_CNT_W'(1);
    localparam logic [CYC_CNT_W-1:0]   CYC_ZERO_C     = CYC_CNT_W'(0);
    localparam logic [MATCH_CNT_W-1:0] MATCH_ZERO_C   = MATCH_CNT_W'(0);
    localparam logic [MATCH_CNT_W-1:0] MATCH_MAX_C    = {MATCH_CNT_W{1'b1}};
    localparam logic [SLIP_CNT_W-1:0]  SLIP_ZERO_C    = SLIP_CNT_W'(0);

    align_state_e           state_d, state_q;
    logic [CYC_CNT_W-1:0]   cyc_cnt_d, cyc_cnt_q;
    logic [MATCH_CNT_W-1:0] match_cnt_d, match_cnt_q;
    logic [SLIP_CNT_W-1:0]  slip_cnt_d, slip_cnt_q;
    logic                   rx_rst_d, rx_rst_q;
    logic                   en_d, en_q;
    logic                   bitslip_d, bitslip_q;
    logic                   aligned_d, aligned_q;
    logic                   align_error_d, align_error_q;

    logic                   lock_s;
    logic                   word_match_s;
    logic [MATCH_CNT_W-1:0] match_inc_s;

    sync_2ff u_lock_sync (
        .clk   (CLK_IN),
        .rst_n (RST),
        .d     (PLL_LOCK),
        .q     (lock_s)
    );

    assign word_match_s = (SERDES_Q == PATTERN_C);
    assign match_inc_s  = (match_cnt_q == MATCH_MAX_C) ? match_cnt_q
                                                       : match_cnt_q + MATCH_CNT_W'(1);

    // Next-state, counter and output decode. Outputs are decoded from the
    // next state so that every output is a flop aligned with the state.
    always_comb begin
        state_d     = state_q;
        cyc_cnt_d   = cyc_cnt_q;
        match_cnt_d = match_cnt_q;
        slip_cnt_d  = slip_cnt_q;

        if (!START) begin
            state_d     = ST_IDLE;
            cyc_cnt_d   = CYC_ZERO_C;
            match_cnt_d = MATCH_ZERO_C;
            slip_cnt_d  = SLIP_ZERO_C;
        end else if (!lock_s && lock_watched(state_q)) begin
            state_d     = ST_WAIT_LOCK;
            cyc_cnt_d   = CYC_ZERO_C;
            match_cnt_d = MATCH_ZERO_C;
            slip_cnt_d  = SLIP_ZERO_C;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    match_cnt_d = MATCH_ZERO_C;
                    slip_cnt_d  = SLIP_ZERO_C;
                    if (lock_s) begin
                        state_d   = ST_RELEASE;
                        cyc_cnt_d = RX_RST_LOAD_C;
                    end else begin
                        state_d   = ST_WAIT_LOCK;
                        cyc_cnt_d = CYC_ZERO_C;
                    end
                end
                ST_RELEASE: begin
                    // Leaving on the edge that takes the count to zero makes
                    // RX_RST rise exactly RX_RST_CYCLES edges after entry.
                    if (cyc_cnt_q <= CYC_ONE_C) begin
                        state_d   = ST_CHECK;
                        cyc_cnt_d = CYC_ZERO_C;
                    end else begin
                        state_d   = ST_RELEASE;
                        cyc_cnt_d = cyc_cnt_q - CYC_ONE_C;
                    end
                end
                ST_CHECK: begin
                    if (SERDES_DATA_VALID) begin
                        if (word_match_s) begin
                            match_cnt_d = match_inc_s;
                            if (match_inc_s >= MATCH_TARGET_C) begin
                                state_d = ST_LOCKED;
                            end else begin
                                state_d = ST_CHECK;
                            end
                        end else begin
                            match_cnt_d = MATCH_ZERO_C;
                            if (slip_cnt_q >= MAX_SLIPS_C) begin
                                state_d = ST_ERROR;
                            end else begin
                                state_d    = ST_SLIP;
                                slip_cnt_d = slip_cnt_q + SLIP_CNT_W'(1);
                            end
                        end
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
                ST_SLIP: begin
                    state_d   = ST_SETTLE;
                    cyc_cnt_d = SETTLE_LOAD_C;
                end
                ST_SETTLE: begin
                    // Only valid beats are discarded; idle cycles do not count.
                    if (SERDES_DATA_VALID) begin
                        if (cyc_cnt_q <= CYC_ONE_C) begin
                            state_d   = ST_CHECK;
                            cyc_cnt_d = CYC_ZERO_C;
                        end else begin
                            state_d   = ST_SETTLE;
                            cyc_cnt_d = cyc_cnt_q - CYC_ONE_C;
                        end
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
                ST_LOCKED: begin
                    state_d = ST_LOCKED;
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: begin
                    state_d     = ST_IDLE;
                    cyc_cnt_d   = CYC_ZERO_C;
                    match_cnt_d = MATCH_ZERO_C;
                    slip_cnt_d  = SLIP_ZERO_C;
                end
            endcase
        end

        rx_rst_d      = serdes_enabled(state_d);
        en_d          = serdes_enabled(state_d);
        bitslip_d     = (state_d == ST_SLIP);
        aligned_d     = (state_d == ST_LOCKED);
        align_error_d = (state_d == ST_ERROR);
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            state_q       <= ST_IDLE;
            cyc_cnt_q     <= CYC_ZERO_C;
            match_cnt_q   <= MATCH_ZERO_C;
            slip_cnt_q    <= SLIP_ZERO_C;
            rx_rst_q      <= 1'b0;
            en_q          <= 1'b0;
            bitslip_q     <= 1'b0;
            aligned_q     <= 1'b0;
            align_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cyc_cnt_q     <= cyc_cnt_d;
            match_cnt_q   <= match_cnt_d;
            slip_cnt_q    <= slip_cnt_d;
            rx_rst_q      <= rx_rst_d;
            en_q          <= en_d;
            bitslip_q     <= bitslip_d;
            aligned_q     <= aligned_d;
            align_error_q <= align_error_d;
        end
    end

    assign RX_RST      = rx_rst_q;
    assign EN          = en_q;
    assign BITSLIP_ADJ = bitslip_q;
    assign ALIGNED     = aligned_q;
    assign ALIGN_ERROR = align_error_q;
    assign SLIP_COUNT  = slip_cnt_q;

endmodule

// File: tb/tb_i_serdes_align_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i_serdes_align_ctrl
// Bench for i_serdes_align_ctrl (WIDTH=4, default parameters). An I_SERDES
// stand-in supplies words and reacts to BITSLIP_ADJ; a behavioural model of
// the controller predicts all outputs and is compared every cycle. Directed
// scenarios add hand-computed timing/count expectations, then randomized
// scenarios exercise valid gaps, noise, lock loss and START toggling.
// ---------------------------------------------------------------------------
module tb_i_serdes_align_ctrl;

    localparam int         W      = 4;
    localparam int         MATCH  = 16;
    localparam int         SWAIT  = 4;
    localparam int         MSLIPS = 10;
    localparam int         RXC    = 8;
    localparam logic [3:0] PAT    = 4'hA;

    // model phases (bench-local numbering)
    localparam int P_IDLE = 0, P_WAIT = 1, P_REL = 2, P_CHECK = 3;
    localparam int P_SLIP = 4, P_SETTLE = 5, P_LOCKED = 6, P_ERROR = 7;

    logic       CLK_IN = 1'b0;
    logic       RST = 1'b0;
    logic       START = 1'b0;
    logic       PLL_LOCK = 1'b0;
    logic [3:0] SERDES_Q = 4'h0;
    logic       SERDES_DATA_VALID = 1'b0;
    logic       RX_RST, EN, BITSLIP_ADJ, ALIGNED, ALIGN_ERROR;
    logic [3:0] SLIP_COUNT;

    i_serdes_align_ctrl #(
        .WIDTH         (W),
        .TRAIN_PATTERN (10'h00A),
        .MATCH_COUNT   (MATCH),
        .SLIP_WAIT     (SWAIT),
        .MAX_SLIPS     (MSLIPS),
        .RX_RST_CYCLES (RXC)
    ) dut (
        .CLK_IN            (CLK_IN),
        .RST               (RST),
        .START             (START),
        .PLL_LOCK          (PLL_LOCK),
        .SERDES_Q          (SERDES_Q),
        .SERDES_DATA_VALID (SERDES_DATA_VALID),
        .RX_RST            (RX_RST),
        .EN                (EN),
        .BITSLIP_ADJ       (BITSLIP_ADJ),
        .ALIGNED           (ALIGNED),
        .ALIGN_ERROR       (ALIGN_ERROR),
        .SLIP_COUNT        (SLIP_COUNT)
    );

    always #5 CLK_IN = ~CLK_IN;

    int n_cmp = 0;
    int n_bad = 0;
    int tcyc  = 0;

    // behavioural model state
    int mp = P_IDLE, m_left = 0, m_match = 0, m_slips = 0;
    bit m_h1 = 1'b0, m_h2 = 1'b0;

    // word source state
    int         src_mode = 0;      // 0: phase source, 1: constant, 2: random noise
    int         src_off = 0;       // slip phases away from the aligned boundary
    logic [3:0] src_const = 4'h0;
    bit         src_follow = 1'b1; // whether BITSLIP_ADJ moves the boundary
    int         valid_pct = 100;
    int         corrupt_at = 0;
    int         beat = 0;

    // per-scenario measurements
    int scen_cyc, n_pulses, first_pulse, last_pulse, min_gap, rx_rise, al_rise, err_rise, m_al_rise;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0d, want %0d", name, tcyc, act, exp);
        end
    endtask

    task automatic clear_meas();
        scen_cyc = 0; n_pulses = 0; first_pulse = -1; last_pulse = -1;
        min_gap = 1000; rx_rise = -1; al_rise = -1; err_rise = -1; m_al_rise = -1;
    endtask

    // Advance the reference controller by one clock edge using the inputs
    // that the DUT sampled on that edge.
    task automatic model_step();
        bit ls;
        if (RST !== 1'b1) begin
            mp = P_IDLE; m_left = 0; m_match = 0; m_slips = 0; m_h1 = 1'b0; m_h2 = 1'b0;
        end else begin
            ls = m_h2; m_h2 = m_h1; m_h1 = PLL_LOCK;
            if (!START) begin
                mp = P_IDLE; m_match = 0; m_slips = 0;
            end else if (!ls && mp >= P_REL && mp <= P_LOCKED) begin
                mp = P_WAIT; m_match = 0; m_slips = 0;
            end else begin
                case (mp)
                    P_IDLE: mp = P_WAIT;
                    P_WAIT: if (ls) begin mp = P_REL; m_left = RXC; end
                    P_REL: begin
                        m_left = m_left - 1;
                        if (m_left == 0) mp = P_CHECK;
                    end
                    P_CHECK: if (SERDES_DATA_VALID) begin
                        if (SERDES_Q == PAT) begin
                            if (m_match < 255) m_match = m_match + 1;
                            if (m_match >= MATCH) mp = P_LOCKED;
                        end else begin
                            m_match = 0;
                            if (m_slips == MSLIPS) mp = P_ERROR;
                            else begin m_slips = m_slips + 1; mp = P_SLIP; end
                        end
                    end
                    P_SLIP: begin mp = P_SETTLE; m_left = SWAIT; end
                    P_SETTLE: if (SERDES_DATA_VALID) begin
                        m_left = m_left - 1;
                        if (m_left == 0) mp = P_CHECK;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic compare_all();
        chk("RX_RST",      RX_RST,      (mp >= P_CHECK) ? 1 : 0);
        chk("EN",          EN,          (mp >= P_CHECK) ? 1 : 0);
        chk("BITSLIP_ADJ", BITSLIP_ADJ, (mp == P_SLIP) ? 1 : 0);
        chk("ALIGNED",     ALIGNED,     (mp == P_LOCKED) ? 1 : 0);
        chk("ALIGN_ERROR", ALIGN_ERROR, (mp == P_ERROR) ? 1 : 0);
        chk("SLIP_COUNT",  SLIP_COUNT,  m_slips);
    endtask

    // I_SERDES stand-in: reacts to the bitslip seen this cycle, then presents
    // the next word and valid flag.
    task automatic drive_inputs();
        logic [3:0] word;
        if (BITSLIP_ADJ === 1'b1 && src_follow) src_off = (src_off + W - 1) % W;
        SERDES_DATA_VALID = ($urandom_range(0, 99) < valid_pct);
        case (src_mode)
            0:       word = (src_off == 0) ? PAT : 4'h5;
            1:       word = src_const;
            default: word = 4'($urandom_range(0, 15));
        endcase
        if (SERDES_DATA_VALID && RX_RST === 1'b1) begin
            beat++;
            if (beat == corrupt_at) word = 4'h3;
        end
        SERDES_Q = word;
    endtask

    task automatic cycle();
        @(negedge CLK_IN);
        tcyc++;
        scen_cyc++;
        model_step();
        compare_all();
        if (BITSLIP_ADJ === 1'b1) begin
            if (last_pulse >= 0 && scen_cyc - last_pulse < min_gap) min_gap = scen_cyc - last_pulse;
            if (first_pulse < 0) first_pulse = scen_cyc;
            last_pulse = scen_cyc;
            n_pulses++;
        end
        if (RX_RST === 1'b1 && rx_rise < 0) rx_rise = scen_cyc;
        if (ALIGNED === 1'b1 && al_rise < 0) al_rise = scen_cyc;
        if (ALIGN_ERROR === 1'b1 && err_rise < 0) err_rise = scen_cyc;
        if (mp == P_LOCKED && m_al_rise < 0) m_al_rise = scen_cyc;
        drive_inputs();
    endtask

    task automatic start_scenario(input int mode, input int off, input logic [3:0] cval,
                                  input bit follow, input int corrupt);
        START = 1'b0;
        PLL_LOCK = 1'b1;
        repeat (3) cycle();
        src_mode = mode; src_off = off; src_const = cval; src_follow = follow;
        corrupt_at = corrupt; valid_pct = 100; beat = 0;
        START = 1'b1;
        clear_meas();
    endtask

    task automatic run_until_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (ALIGNED === 1'b1 || ALIGN_ERROR === 1'b1) break;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_meas();
        repeat (3) cycle();
        chk("reset RX_RST", RX_RST, 0);
        chk("reset EN", EN, 0);
        chk("reset SLIP_COUNT", SLIP_COUNT, 0);
        RST = 1'b1;

        // 1: aligned source, no slips
        start_scenario(0, 0, 4'h0, 1'b1, 0);
        run_until_done(200);
        chk("t1 rx_rise_cycle", rx_rise, 2 + RXC);
        chk("t1 aligned_cycle", al_rise, 2 + RXC + MATCH);
        chk("t1 model_aligned_cycle", m_al_rise, 26);
        chk("t1 pulses", n_pulses, 0);
        chk("t1 SLIP_COUNT", SLIP_COUNT, 0);

        // 5: lock loss while LOCKED, then relock
        clear_meas();
        PLL_LOCK = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (ALIGNED === 1'b0 && RX_RST === 1'b0) break;
        end
        chk("t5 lockloss_edges", scen_cyc, 3);
        repeat (3) cycle();
        PLL_LOCK = 1'b1;
        clear_meas();
        run_until_done(200);
        chk("t5 relock_rx_rise", rx_rise, 11);
        chk("t5 realigned_cycle", al_rise, 27);

        // 2: three slip phases off
        start_scenario(0, 3, 4'h0, 1'b1, 0);
        run_until_done(300);
        chk("t2 pulses", n_pulses, 3);
        chk("t2 first_pulse", first_pulse, 11);
        chk("t2 min_gap", min_gap, SWAIT + 2);
        chk("t2 ALIGNED", ALIGNED, 1);
        chk("t2 aligned_cycle", al_rise, 44);
        chk("t2 SLIP_COUNT", SLIP_COUNT, 3);

        // 3: stuck source exhausts the slip budget
        start_scenario(1, 0, 4'hF, 1'b1, 0);
        run_until_done(400);
        chk("t3 pulses", n_pulses, MSLIPS);
        chk("t3 error_cycle", err_rise, 71);
        chk("t3 ALIGN_ERROR", ALIGN_ERROR, 1);
        chk("t3 ALIGNED", ALIGNED, 0);
        chk("t3 SLIP_COUNT", SLIP_COUNT, 10);
        START = 1'b0;
        cycle();
        chk("t3 idle ALIGN_ERROR", ALIGN_ERROR, 0);
        chk("t3 idle SLIP_COUNT", SLIP_COUNT, 0);
        chk("t3 idle EN", EN, 0);

        // 4: one corrupted beat in an otherwise aligned stream
        start_scenario(0, 0, 4'h0, 1'b0, 15);
        run_until_done(300);
        chk("t4 pulses", n_pulses, 1);
        chk("t4 first_pulse", first_pulse, 25);
        chk("t4 aligned_cycle", al_rise, 46);
        chk("t4 SLIP_COUNT", SLIP_COUNT, 1);

        // 6: asynchronous reset during SETTLE
        start_scenario(0, 3, 4'h0, 1'b1, 0);
        while (scen_cyc < 12) cycle();
        chk("t6 pre_reset SLIP_COUNT", SLIP_COUNT, 1);
        #2;
        RST = 1'b0;
        #1;
        chk("t6 async RX_RST", RX_RST, 0);
        chk("t6 async EN", EN, 0);
        chk("t6 async SLIP_COUNT", SLIP_COUNT, 0);
        START = 1'b0;
        repeat (2) cycle();
        RST = 1'b1;
        repeat (4) cycle();
        chk("t6 idle_held RX_RST", RX_RST, 0);
        START = 1'b1;
        clear_meas();
        run_until_done(300);
        chk("t6 restart_rx_rise", rx_rise, 10);
        chk("t6 restart ALIGNED", ALIGNED, 1);

        // randomized scenarios
        for (int s = 0; s < 20; s++) begin
            START = 1'b0;
            PLL_LOCK = 1'b1;
            repeat (3) cycle();
            src_mode = $urandom_range(0, 2);
            src_off = $urandom_range(0, 3);
            src_const = 4'($urandom_range(0, 15));
            src_follow = 1'b1;
            corrupt_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
            valid_pct = $urandom_range(40, 100);
            beat = 0;
            START = 1'b1;
            for (int c = 0; c < 250; c++) begin
                cycle();
                if (PLL_LOCK && $urandom_range(0, 199) == 0) PLL_LOCK = 1'b0;
                else if (!PLL_LOCK && $urandom_range(0, 7) == 0) PLL_LOCK = 1'b1;
                if (START && $urandom_range(0, 299) == 0) START = 1'b0;
                else if (!START && $urandom_range(0, 4) == 0) START = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
